// File: rtl/e_unit_pkg.sv
// rtl/e_unit_pkg.sv - shared opcode/funct constants and helpers for the stage units
//
// Purpose: MIPS opcode/funct encodings, operand-forwarding select codes,
//          mult/div operation type and latencies, and the forwarding mux
//          helper shared by the pipeline stage units.
// Ports:   none (package)
package e_unit_pkg;

  // I-type opcodes (R-type instructions use opcode 0)
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_SLTU  = 6'h2B;

  // Operand forwarding select codes; any other code keeps the D/E register value
  localparam logic [2:0] FWD_AO_M = 3'd1;
  localparam logic [2:0] FWD_PC4_M = 3'd2;
  localparam logic [2:0] FWD_W_WD = 3'd3;

  // Mult/div operation and the number of busy cycles after the start cycle
  typedef enum logic [1:0] {
    MD_MULT,
    MD_MULTU,
    MD_DIV,
    MD_DIVU
  } md_op_e;

  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  function automatic logic [31:0] fwd_sel(
    input logic [2:0]  src,
    input logic [31:0] reg_val,
    input logic [31:0] ao_m,
    input logic [31:0] pc4_m,
    input logic [31:0] w_wd
  );
    case (src)
      FWD_AO_M:  return ao_m;
      FWD_PC4_M: return pc4_m;
      FWD_W_WD:  return w_wd;
      default:   return reg_val;
    endcase
  endfunction

endpackage

// File: rtl/md_E.sv
// rtl/md_E.sv - E-stage multi-cycle multiply/divide unit with HI/LO
//
// Purpose: latches operands on start, counts down the operation latency and
//          writes HI/LO when the count reaches zero; also serves mthi/mtlo.
// Ports:
//   clk     in   1   clock
//   resetn  in   1   synchronous active-low reset
//   start   in   1   E-stage instruction is mult/multu/div/divu
//   op      in   2   which mult/div operation
//   a       in  32   forwarded rs (also mthi/mtlo data)
//   b       in  32   forwarded rt
//   mthi    in   1   E-stage instruction is mthi
//   mtlo    in   1   E-stage instruction is mtlo
//   hi      out 32   HI register
//   lo      out 32   LO register
//   busy    out  1   start or operation in flight
module md_E
  import e_unit_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  md_op_e      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy
);

  logic [3:0]  count;
  md_op_e      op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic signed [32:0] sa;
  logic signed [32:0] sb;
  logic signed [32:0] quot_s;
  logic signed [32:0] rem_s;
  logic [31:0] quot_u;
  logic [31:0] rem_u;
  logic        unused_md;

  assign prod_s = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
  assign prod_u = {32'h0, a_q} * {32'h0, b_q};

  // 33-bit signed divide so that -2^31 / -1 wraps instead of overflowing
  assign sa     = {a_q[31], a_q};
  assign sb     = {b_q[31], b_q};
  assign quot_s = sa / sb;
  assign rem_s  = sa % sb;
  assign quot_u = a_q / b_q;
  assign rem_u  = a_q % b_q;
  assign unused_md = quot_s[32] ^ rem_s[32];

  assign busy = start | (count != 4'd0);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      count <= 4'd0;
      op_q  <= MD_MULT;
      a_q   <= 32'h0;
      b_q   <= 32'h0;
      hi    <= 32'h0;
      lo    <= 32'h0;
    end else if (count == 4'd0) begin
      if (start) begin
        op_q  <= op;
        a_q   <= a;
        b_q   <= b;
        count <= (op == MD_MULT || op == MD_MULTU) ? MULT_CYCLES : DIV_CYCLES;
      end else if (mthi) begin
        hi <= a;
      end else if (mtlo) begin
        lo <= a;
      end
    end else begin
      // Start and mthi/mtlo are dropped while an operation is in flight
      count <= count - 4'd1;
      if (count == 4'd1) begin
        case (op_q)
          MD_MULT:  {hi, lo} <= prod_s;
          MD_MULTU: {hi, lo} <= prod_u;
          MD_DIV: begin
            if (b_q != 32'h0) begin
              lo <= quot_s[31:0];
              hi <= rem_s[31:0];
            end
          end
          MD_DIVU: begin
            if (b_q != 32'h0) begin
              lo <= quot_u;
              hi <= rem_u;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/e_unit.sv
// rtl/e_unit.sv - MIPS execute stage: forwarding muxes, ALU, mult/div and E/M register
//
// Purpose: selects forwarded operands, computes the E-stage result, drives the
//          mult/div unit and registers the E/M pipeline values.
// Ports:
//   Clk               in   1   clock
//   Reset             in   1   synchronous active-low reset
//   IRE               in  32   E-stage instruction
//   PC4E              in  32   E-stage PC+4
//   RSE, RTE          in  32   rs/rt values from D/E register
//   EXTE              in  32   extended immediate
//   Forward_RS_E_src  in   3   rs operand select
//   Forward_RT_E_src  in   3   rt operand select
//   AO_M              in  32   M-stage ALU result
//   PC4_forw_M        in  32   M-stage link value
//   W_RF_WD_OUT       in  32   W-stage write data
//   Busy              out  1   mult/div occupied
//   IRM, PC4M, AOM, RTM out 32 E/M register outputs
module e_unit
  import e_unit_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IRE,
  input  logic [31:0] PC4E,
  input  logic [31:0] RSE,
  input  logic [31:0] RTE,
  input  logic [31:0] EXTE,
  input  logic [2:0]  Forward_RS_E_src,
  input  logic [2:0]  Forward_RT_E_src,
  input  logic [31:0] AO_M,
  input  logic [31:0] PC4_forw_M,
  input  logic [31:0] W_RF_WD_OUT,
  output logic        Busy,
  output logic [31:0] IRM,
  output logic [31:0] PC4M,
  output logic [31:0] AOM,
  output logic [31:0] RTM
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        is_rtype;
  logic [31:0] a;
  logic [31:0] rt_fwd;
  logic [31:0] b;
  logic [31:0] r;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        start;
  logic        do_mthi;
  logic        do_mtlo;
  md_op_e      md_op;
  logic        unused_ire;

  assign opcode     = IRE[31:26];
  assign funct      = IRE[5:0];
  assign is_rtype   = (opcode == OP_RTYPE);
  assign unused_ire = ^IRE[25:16];

  assign a      = fwd_sel(Forward_RS_E_src, RSE, AO_M, PC4_forw_M, W_RF_WD_OUT);
  assign rt_fwd = fwd_sel(Forward_RT_E_src, RTE, AO_M, PC4_forw_M, W_RF_WD_OUT);
  assign b      = is_rtype ? rt_fwd : EXTE;

  always_comb begin
    start   = 1'b0;
    do_mthi = 1'b0;
    do_mtlo = 1'b0;
    md_op   = MD_MULT;
    if (is_rtype) begin
      case (funct)
        FN_MULT:  begin start = 1'b1; md_op = MD_MULT;  end
        FN_MULTU: begin start = 1'b1; md_op = MD_MULTU; end
        FN_DIV:   begin start = 1'b1; md_op = MD_DIV;   end
        FN_DIVU:  begin start = 1'b1; md_op = MD_DIVU;  end
        FN_MTHI:  do_mthi = 1'b1;
        FN_MTLO:  do_mtlo = 1'b1;
        default:  ;
      endcase
    end
  end

  always_comb begin
    r = 32'h0;
    if (is_rtype) begin
      case (funct)
        FN_ADDU: r = a + b;
        FN_SUBU: r = a - b;
        FN_AND:  r = a & b;
        FN_OR:   r = a | b;
        FN_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        FN_SLTU: r = (a < b) ? 32'd1 : 32'd0;
        FN_MFHI: r = hi;
        FN_MFLO: r = lo;
        default: r = 32'h0;
      endcase
    end else begin
      case (opcode)
        OP_ADDIU, OP_LW, OP_SW: r = a + b;
        OP_ORI:  r = a | b;
        OP_LUI:  r = {IRE[15:0], 16'h0};
        default: r = 32'h0;
      endcase
    end
  end

  md_E u_md (
    .clk    (Clk),
    .resetn (Reset),
    .start  (start),
    .op     (md_op),
    .a      (a),
    .b      (rt_fwd),
    .mthi   (do_mthi),
    .mtlo   (do_mtlo),
    .hi     (hi),
    .lo     (lo),
    .busy   (Busy)
  );

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      IRM  <= 32'h0;
      PC4M <= 32'h0;
      AOM  <= 32'h0;
      RTM  <= 32'h0;
    end else begin
      IRM  <= IRE;
      PC4M <= PC4E;
      AOM  <= r;
      RTM  <= rt_fwd;
    end
  end

endmodule

// File: tb/tb_e_unit.sv
// tb/tb_e_unit.sv - self-checking bench for e_unit
module tb_e_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [31:0] IRE = 32'h0, PC4E = 32'h0, RSE = 32'h0, RTE = 32'h0, EXTE = 32'h0;
  logic [2:0]  Forward_RS_E_src = 3'd0, Forward_RT_E_src = 3'd0;
  logic [31:0] AO_M = 32'h0, PC4_forw_M = 32'h0, W_RF_WD_OUT = 32'h0;
  logic        Busy;
  logic [31:0] IRM, PC4M, AOM, RTM;

  int n_tests = 0;
  int n_fail = 0;
  logic [31:0] m_hi = 32'h0;
  logic [31:0] m_lo = 32'h0;

  always #5 Clk = ~Clk;

  e_unit dut (
    .Clk(Clk), .Reset(Reset), .IRE(IRE), .PC4E(PC4E), .RSE(RSE), .RTE(RTE),
    .EXTE(EXTE), .Forward_RS_E_src(Forward_RS_E_src),
    .Forward_RT_E_src(Forward_RT_E_src), .AO_M(AO_M), .PC4_forw_M(PC4_forw_M),
    .W_RF_WD_OUT(W_RF_WD_OUT), .Busy(Busy), .IRM(IRM), .PC4M(PC4M), .AOM(AOM),
    .RTM(RTM)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd3, 5'd4, 5'd5, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [15:0] imm);
    return {op, 5'd3, 5'd4, imm};
  endfunction

  function automatic logic [31:0] pick(input logic [2:0] src, input logic [31:0] rv);
    case (src)
      3'd1: return AO_M;
      3'd2: return PC4_forw_M;
      3'd3: return W_RF_WD_OUT;
      default: return rv;
    endcase
  endfunction

  // Reference result of one E-stage instruction from the instruction-set rules
  function automatic logic [31:0] alu_ref(input logic [31:0] ire, input logic [31:0] a,
                                          input logic [31:0] rt, input logic [31:0] ext);
    logic [5:0] op;
    logic [5:0] fn;
    logic [31:0] b;
    op = ire[31:26];
    fn = ire[5:0];
    b = (op == 6'h00) ? rt : ext;
    if (op == 6'h00) begin
      case (fn)
        6'h21: return a + b;
        6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h2A: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
        6'h2B: return (longint'({32'h0, a}) < longint'({32'h0, b})) ? 32'd1 : 32'd0;
        6'h10: return m_hi;
        6'h12: return m_lo;
        default: return 32'h0;
      endcase
    end
    case (op)
      6'h09, 6'h23, 6'h2B: return a + b;
      6'h0D: return a | b;
      6'h0F: return {ire[15:0], 16'h0};
      default: return 32'h0;
    endcase
  endfunction

  task automatic set_instr(input logic [31:0] ire, input logic [31:0] rse, input logic [31:0] rte,
                           input logic [31:0] ext, input logic [2:0] srs, input logic [2:0] srt);
    IRE = ire; RSE = rse; RTE = rte; EXTE = ext;
    Forward_RS_E_src = srs; Forward_RT_E_src = srt;
    PC4E = $urandom; AO_M = $urandom; PC4_forw_M = $urandom; W_RF_WD_OUT = $urandom;
  endtask

  // One non-mult/div instruction through E: checks Busy and the E/M register
  task automatic exec_alu(input string tag);
    logic [31:0] a, rt, exp_r, ire_q, pc_q;
    a = pick(Forward_RS_E_src, RSE);
    rt = pick(Forward_RT_E_src, RTE);
    exp_r = alu_ref(IRE, a, rt, EXTE);
    ire_q = IRE;
    pc_q = PC4E;
    #1;
    check({tag, "_busy"}, 32'(Busy), 32'd0);
    cyc();
    check({tag, "_aom"}, AOM, exp_r);
    check({tag, "_rtm"}, RTM, rt);
    check({tag, "_irm"}, IRM, ire_q);
    check({tag, "_pc4m"}, PC4M, pc_q);
    if (ire_q[31:26] == 6'h00 && ire_q[5:0] == 6'h11) m_hi = a;
    if (ire_q[31:26] == 6'h00 && ire_q[5:0] == 6'h13) m_lo = a;
  endtask

  // One mult/div instruction: counts busy cycles and updates the HI/LO model
  task automatic exec_md(input string tag);
    logic [31:0] a, b;
    logic [5:0]  fn;
    longint      sp, sq, sr;
    logic [63:0] up;
    int          bc, want;
    a = pick(Forward_RS_E_src, RSE);
    b = pick(Forward_RT_E_src, RTE);
    fn = IRE[5:0];
    want = (fn == 6'h18 || fn == 6'h19) ? 6 : 11;
    #1;
    check({tag, "_busy0"}, 32'(Busy), 32'd1);
    bc = 1;
    cyc();
    IRE = 32'h0;
    #1;
    while (Busy === 1'b1 && bc < 20) begin
      bc++;
      cyc();
    end
    check({tag, "_busy_cycles"}, 32'(bc), 32'(want));
    case (fn)
      6'h18: begin sp = longint'(int'(a)) * longint'(int'(b)); {m_hi, m_lo} = sp; end
      6'h19: begin up = {32'h0, a} * {32'h0, b}; {m_hi, m_lo} = up; end
      6'h1A: if (b != 32'h0) begin
        sq = longint'(int'(a)) / longint'(int'(b));
        sr = longint'(int'(a)) % longint'(int'(b));
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      default: if (b != 32'h0) begin m_lo = a / b; m_hi = a % b; end
    endcase
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'h7FFF_FFFF;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] ire;
    logic [15:0] imm;
    // Reset: outputs cleared, Busy follows Start only, Start does not launch
    set_instr(rtype(6'h21), 32'h11, 32'h22, 32'h0, 3'd0, 3'd0);
    #1;
    check("rst_busy_idle", 32'(Busy), 32'd0);
    cyc();
    check("rst_irm", IRM, 32'h0);
    check("rst_pc4m", PC4M, 32'h0);
    check("rst_aom", AOM, 32'h0);
    check("rst_rtm", RTM, 32'h0);
    set_instr(rtype(6'h18), 32'h5, 32'h6, 32'h0, 3'd0, 3'd0);
    #1;
    check("rst_busy_start", 32'(Busy), 32'd1);
    cyc();
    IRE = 32'h0;
    #1;
    check("rst_no_launch", 32'(Busy), 32'd0);
    Reset = 1'b1;

    set_instr(rtype(6'h10), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("mfhi_init");

    set_instr(rtype(6'h21), 32'h7FFF_FFFF, 32'h1, 32'h0, 3'd0, 3'd0);
    exec_alu("addu_wrap");
    check("addu_wrap_const", AOM, 32'h8000_0000);

    set_instr(rtype(6'h2A), 32'hFFFF_FFFF, 32'h1, 32'h0, 3'd0, 3'd0);
    exec_alu("slt");
    check("slt_const", AOM, 32'd1);
    set_instr(rtype(6'h2B), 32'hFFFF_FFFF, 32'h1, 32'h0, 3'd0, 3'd0);
    exec_alu("sltu");
    check("sltu_const", AOM, 32'd0);

    set_instr(itype(6'h0D, 16'hFFFF), 32'hDEAD_BEEF, 32'h0, 32'h0000_FFFF, 3'd1, 3'd0);
    AO_M = 32'h1234_5678;
    exec_alu("ori_fwd");
    check("ori_fwd_const", AOM, 32'h1234_FFFF);

    set_instr(rtype(6'h18), 32'hFFFF_FFFE, 32'h3, 32'h0, 3'd0, 3'd0);
    exec_md("mult");
    set_instr(rtype(6'h10), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("mult_hi");
    check("mult_hi_const", AOM, 32'hFFFF_FFFF);
    set_instr(rtype(6'h12), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("mult_lo");
    check("mult_lo_const", AOM, 32'hFFFF_FFFA);

    set_instr(rtype(6'h19), 32'hFFFF_FFFE, 32'h3, 32'h0, 3'd0, 3'd0);
    exec_md("multu");
    set_instr(rtype(6'h10), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("multu_hi");
    check("multu_hi_const", AOM, 32'h0000_0002);
    set_instr(rtype(6'h12), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("multu_lo");
    check("multu_lo_const", AOM, 32'hFFFF_FFFA);

    set_instr(rtype(6'h1A), 32'hFFFF_FFF9, 32'h2, 32'h0, 3'd0, 3'd0);
    exec_md("div");
    set_instr(rtype(6'h12), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("div_lo");
    check("div_lo_const", AOM, 32'hFFFF_FFFD);
    set_instr(rtype(6'h10), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("div_hi");
    check("div_hi_const", AOM, 32'hFFFF_FFFF);

    set_instr(rtype(6'h1B), 32'h1234_5678, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_md("divu_zero");
    set_instr(rtype(6'h10), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("divz_hi");
    check("divz_hi_const", AOM, 32'hFFFF_FFFF);
    set_instr(rtype(6'h12), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("divz_lo");
    check("divz_lo_const", AOM, 32'hFFFF_FFFD);

    // Randomized instruction mix against the reference model
    for (int i = 0; i < 150; i++) begin
      imm = 16'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        ire = rtype(6'(6'h18 + $urandom_range(0, 3)));
        set_instr(ire, rnd_val(), rnd_val(), $urandom, 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)));
        if ($urandom_range(0, 5) == 0) begin RTE = 32'h0; Forward_RT_E_src = 3'd0; end
        exec_md("rnd_md");
      end else begin
        case ($urandom_range(0, 15))
          0: ire = rtype(6'h21);
          1: ire = rtype(6'h23);
          2: ire = rtype(6'h24);
          3: ire = rtype(6'h25);
          4: ire = rtype(6'h2A);
          5: ire = rtype(6'h2B);
          6: ire = rtype(6'h10);
          7: ire = rtype(6'h12);
          8: ire = rtype(6'h11);
          9: ire = rtype(6'h13);
          10: ire = itype(6'h09, imm);
          11: ire = itype(6'h0D, imm);
          12: ire = itype(6'h0F, imm);
          13: ire = itype(6'h23, imm);
          14: ire = itype(6'h2B, imm);
          default: ire = itype(6'h04, imm);
        endcase
        set_instr(ire, rnd_val(), rnd_val(), {{16{imm[15]}}, imm},
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        exec_alu("rnd_alu");
      end
    end

    // Reset during the third busy cycle of a divide aborts it and clears HI/LO
    set_instr(rtype(6'h11), 32'hA5A5_A5A5, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("pre_mthi");
    set_instr(rtype(6'h1A), 32'd100, 32'd7, 32'h0, 3'd0, 3'd0);
    cyc();
    IRE = 32'h0;
    cyc();
    set_instr(rtype(6'h21), 32'h5, 32'h6, 32'h0, 3'd0, 3'd0);
    Reset = 1'b0;
    #1;
    check("abort_busy_before", 32'(Busy), 32'd1);
    cyc();
    check("abort_busy_after", 32'(Busy), 32'd0);
    check("abort_irm", IRM, 32'h0);
    check("abort_pc4m", PC4M, 32'h0);
    check("abort_aom", AOM, 32'h0);
    check("abort_rtm", RTM, 32'h0);
    Reset = 1'b1;
    m_hi = 32'h0;
    m_lo = 32'h0;
    IRE = 32'h0;
    for (int k = 0; k < 10; k++) cyc();
    set_instr(rtype(6'h10), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("abort_hi");
    set_instr(rtype(6'h12), 32'h0, 32'h0, 32'h0, 3'd0, 3'd0);
    exec_alu("abort_lo");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
